// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: shared state encoding for the divider issue sequencer
package div_issue_ctrl_pkg;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;
endpackage

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage sequencer that issues DIV/DIVU to the divider and writes HI/LO
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   reg1_i,
  input  logic [DATA_W-1:0]   reg2_i,
  input  logic                flush_i,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_opdata1_o,
  output logic [DATA_W-1:0]   div_opdata2_o,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                div_ready_i,
  output logic                stallreq_o,
  output logic                whilo_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                timeout_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  div_state_e    state;
  logic [CW-1:0] cnt;
  logic          busy, expire;
  assign busy         = state == DIV_BUSY;
  assign expire       = busy && !div_ready_i && cnt == CW'(TIMEOUT - 1);
  assign div_annul_o  = busy && (flush_i || expire);
  assign div_start_o  = busy && !div_annul_o;
  assign stallreq_o   = busy || (state == DIV_IDLE && div_i && !flush_i);
  assign whilo_o      = state == DIV_DONE && !flush_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= DIV_IDLE;
      cnt           <= '0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      hi_o          <= '0;
      lo_o          <= '0;
      timeout_o     <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      if (state == DIV_IDLE) begin
        if (div_i && !flush_i) begin
          div_signed_o  <= signed_i;
          div_opdata1_o <= reg1_i;
          div_opdata2_o <= reg2_i;
          cnt           <= '0;
          state         <= DIV_BUSY;
        end
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        if (flush_i) begin
          state <= DIV_IDLE;
        end else if (div_ready_i) begin
          hi_o  <= div_result_i[2*DATA_W-1:DATA_W];
          lo_o  <= div_result_i[DATA_W-1:0];
          state <= DIV_DONE;
        end else if (expire) begin
          timeout_o <= 1'b1;
          state     <= DIV_IDLE;
        end
      end else begin
        state <= DIV_IDLE;
      end
    end
  end
endmodule
